// File: rtl/ripple_count_extender_pkg.sv
// Shared constants and helpers for the ripple counter extender and its snapshot FIFO.
package ripple_count_extender_pkg;

    localparam int SYNC_STAGES = 2;
    localparam int EXT_W_DEF   = 16;
    localparam int DEPTH_DEF   = 4;

    // Level counter needs one extra bit so that "full" (== DEPTH) is representable.
    function automatic int lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/ripple_count_extender_snap_fifo.sv
// First-word fall-through snapshot FIFO with a sticky overflow flag for dropped pushes.
module snap_fifo
    import ripple_count_extender_pkg::*;
#(
    parameter int W     = EXT_W_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  logic [W-1:0]            push_data,
    input  logic                    pop,
    input  logic                    clr_ovf,
    output logic                    out_valid,
    output logic [W-1:0]            out_data,
    output logic [lvl_w(DEPTH)-1:0] level,
    output logic                    overflow
);

    localparam int LW = lvl_w(DEPTH);
    localparam int AW = LW - 1;

    logic [LW-1:0] wr_ptr, rd_ptr;
    logic [W-1:0]  mem [DEPTH];
    logic          empty, full, pop_ok, push_ok, drop;

    assign level   = wr_ptr - rd_ptr;
    assign empty   = (level == '0);
    assign full    = (level == LW'(DEPTH));
    assign pop_ok  = pop && !empty;
    // A pop frees the slot in the same cycle, so a full FIFO still accepts a push.
    assign push_ok = push && (!full || pop_ok);
    assign drop    = push && full && !pop_ok;

    assign out_valid = !empty;
    assign out_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            if (drop)         overflow <= 1'b1;
            else if (clr_ovf) overflow <= 1'b0;
        end
    end

endmodule

// File: rtl/ripple_count_extender.sv
// Extends an asynchronous 3-bit ripple counter: synchronize, filter transients,
// count wraps into an upper field, and queue snapshots of the extended count.
module ripple_count_extender
    import ripple_count_extender_pkg::*;
#(
    parameter int EXT_W = EXT_W_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [2:0]              q_in,
    input  logic                    snap_req,
    input  logic                    out_ready,
    input  logic                    clr_ovf,
    output logic [EXT_W-1:0]        count_ext,
    output logic                    wrap_pulse,
    output logic                    out_valid,
    output logic [EXT_W-1:0]        out_data,
    output logic [lvl_w(DEPTH)-1:0] fifo_level,
    output logic                    overflow
);

    localparam int UP_W = EXT_W - 3;

    logic [SYNC_STAGES-1:0][2:0] sync_q;
    logic [2:0]                  s2, s2_prev, stab;
    logic [UP_W-1:0]             upper;
    logic                        agree_new;

    assign s2        = sync_q[SYNC_STAGES-1];
    // Only a value seen on two consecutive samples is trusted; ripple transients never agree.
    assign agree_new = (s2 == s2_prev) && (s2 != stab);
    assign count_ext = {upper, stab};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= '0;
            s2_prev    <= '0;
            stab       <= '0;
            upper      <= '0;
            wrap_pulse <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], q_in};
            s2_prev    <= s2;
            wrap_pulse <= 1'b0;
            if (agree_new) begin
                stab <= s2;
                // Upper field rolls over silently at all-ones.
                if (s2 < stab) begin
                    upper      <= upper + 1'b1;
                    wrap_pulse <= 1'b1;
                end
            end
        end
    end

    snap_fifo #(
        .W     (EXT_W),
        .DEPTH (DEPTH)
    ) u_snap_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (snap_req),
        .push_data (count_ext),
        .pop       (out_ready),
        .clr_ovf   (clr_ovf),
        .out_valid (out_valid),
        .out_data  (out_data),
        .level     (fifo_level),
        .overflow  (overflow)
    );

endmodule

// File: doc/ripple_count_extender.md
RIPPLE_COUNT_EXTENDER -- requirements
Module: ripple_count_extender

Interface
REQ-001 The block SHALL have parameter EXT_W, default 16, giving the extended count width (minimum 4).
REQ-002 The block SHALL have parameter DEPTH, default 4, giving the snapshot FIFO depth (power of two, at least 2).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port q_in, input, 3 bits: ripple-counter value, asynchronous to clk.
REQ-006 The block SHALL have port snap_req, input, 1 bit: one-cycle request to capture count_ext.
REQ-007 The block SHALL have port out_ready, input, 1 bit: consumer accepts out_data.
REQ-008 The block SHALL have port clr_ovf, input, 1 bit: clears overflow.
REQ-009 The block SHALL have port count_ext, output, EXT_W bits: {wrap counter, stable 3-bit sample}.
REQ-010 The block SHALL have port wrap_pulse, output, 1 bit: one-cycle pulse on each detected wrap.
REQ-011 The block SHALL have port out_valid, output, 1 bit: FIFO not empty.
REQ-012 The block SHALL have port out_data, output, EXT_W bits: FIFO head.
REQ-013 The block SHALL have port fifo_level, output, clog2(DEPTH)+1 bits: entries held.
REQ-014 The block SHALL have port overflow, output, 1 bit: sticky flag for a dropped snapshot.

Function
REQ-015 Each q_in bit SHALL pass through a 2-flop synchronizer; s2 is the second-stage value and s2_prev is s2 delayed one cycle.
REQ-016 The stable value stab SHALL update to s2 only when s2 == s2_prev and s2 != stab; otherwise stab holds, filtering ripple transients.
REQ-017 A wrap SHALL be detected when stab updates to a value numerically less than its old value.
REQ-018 On a wrap, the upper counter (EXT_W-3 bits) SHALL increment modulo 2^(EXT_W-3), and wrap_pulse SHALL be 1 for exactly that cycle.
REQ-019 count_ext SHALL equal {upper, stab}, registered, updating in the same cycle as stab.
REQ-020 Latency from a q_in change to count_ext SHALL be 4 clk cycles when q_in is stable from before edge 1: two synchronizer cycles, one agreement cycle, one update cycle.
REQ-021 A snap_req sampled high SHALL push the count_ext value present in that cycle, i.e. the pre-update value.
REQ-022 The FIFO SHALL be first-word fall-through: out_data is valid whenever out_valid = 1, and a pop occurs on out_valid && out_ready.
REQ-023 A push into an empty FIFO SHALL make out_valid = 1 the next cycle, with no same-cycle bypass.
REQ-024 A push while full and not popping SHALL be dropped, with overflow set to 1 the next cycle.
REQ-025 A push and pop in the same cycle while full SHALL both succeed, leaving the level unchanged and overflow unchanged.
REQ-026 When clr_ovf and a dropped push occur in the same cycle, the set SHALL win.
REQ-027 A pop while empty SHALL be ignored.
REQ-028 Upper-counter wrap from all-ones to 0 SHALL be silent, with no flag.

Reset
REQ-029 rst_n low SHALL immediately clear the synchronizers, s2_prev, stab, upper, wrap_pulse, FIFO pointers and overflow.
REQ-030 After reset: count_ext = 0, out_valid = 0, fifo_level = 0, overflow = 0, wrap_pulse = 0.
REQ-031 A reset asserted mid-operation SHALL discard all FIFO contents, with no partial pop visible.
REQ-032 After reset release, the first stab update SHALL NOT count as a wrap, since stab starts at 0 and no value is less than 0.

Structure
REQ-033 A shared package SHALL hold the SYNC_STAGES = 2 constant, the default EXT_W and DEPTH, and a level-width function.
REQ-034 The snapshot FIFO SHALL be a sub-module named snap_fifo, parameterised by width and depth.
REQ-035 Synchronizer, filter and extender logic SHALL live in ripple_count_extender.

Verification
REQ-036 Scenario: q_in steps 0..7 then 0, each value held for 6 cycles -> count_ext ends at 0x0008, and exactly one wrap_pulse is seen.
REQ-037 Scenario: q_in goes 3 -> 2 (1 cycle glitch) -> 4, the glitch held for fewer than 2 cycles -> stab goes 3 -> 4 directly, with no wrap.
REQ-038 Scenario: DEPTH=4, out_ready = 0, 5 snap_req pulses -> fifo_level = 4 and overflow = 1; after clr_ovf, overflow = 0.
REQ-039 Scenario: full FIFO, snap_req and out_ready high together -> level stays 4, overflow stays 0, and the oldest entry pops.
REQ-040 Scenario: rst_n pulsed low for 1 cycle while FIFO level = 2 and stab = 5 -> all outputs 0 immediately, and out_valid = 0.
REQ-041 Scenario: EXT_W = 4, 2 wraps driven -> upper goes 0 -> 1 -> 0, with wrap_pulse high twice and no flag.
